ysyx_23060077_riscv_dmem_resp: RTL and testbench

Data-memory responder serving the LSU's load/store requests from the far side of the memory interface. Accepts one request at a time over a valid/ready request channel, performs a byte-lane-aware read or masked write on an internal word array, and returns the result over a valid/ready response channel after a fixed, parameterised latency. It replaces the simulation-only pmem path for data accesses, so it is synthesizable and cycle-accurate.

---
 rtl/ysyx_23060077_riscv_dmem_resp.sv | 130 +++++++++++++
 tb/tb_ysyx_23060077_riscv_dmem_resp.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_riscv_dmem_resp.sv
// Data-memory responder for the LSU. It serves one request at a time and applies a
// byte-lane masked write or a right-aligned read. The response appears a fixed number of cycles later.
module ysyx_23060077_riscv_dmem_resp #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic [31:0]   w_offset;
  logic [AW-1:0] w_widx;
  logic [1:0]    w_lane;
  logic [4:0]    w_shift;
  logic          w_oor;
  logic          w_err;
  logic [31:0]   w_word;
  logic [31:0]   w_word_sh;
  logic [31:0]   w_rd;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_sh;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_offset = req_addr - ADDR_BASE;
  assign w_widx   = w_offset[AW+1:2];
  assign w_lane   = req_addr[1:0];
  assign w_shift  = {w_lane, 3'b000};
  // The offset is byte-granular, so the array span in bytes is the range limit.
  assign w_oor    = (req_addr < ADDR_BASE) || (w_offset >= 32'(DEPTH_WORDS * 4));

  assign w_err = w_oor || (req_size == 2'd3) ||
                 ((req_size == 2'd1) && w_lane[0]) ||
                 ((req_size == 2'd2) && (w_lane != 2'd0));

  assign w_word    = r_mem[w_widx];
  assign w_word_sh = w_word >> w_shift;

  always_comb begin
    w_rd = 32'd0;
    w_be = 4'b0000;
    case (req_size)
      2'd0: begin
        w_rd = {24'd0, w_word_sh[7:0]};
        w_be = 4'b0001;
      end
      2'd1: begin
        w_rd = {16'd0, w_word_sh[15:0]};
        w_be = 4'b0011;
      end
      2'd2: begin
        w_rd = w_word_sh;
        w_be = 4'b1111;
      end
      default: begin
        w_rd = 32'd0;
        w_be = 4'b0000;
      end
    endcase
    w_be = w_be << w_lane;
    if (w_err || req_wen) w_rd = 32'd0;
  end

  assign w_wdata_sh = req_wdata << w_shift;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (r_cnt == 4'd0) w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rdata <= w_rd;
        r_err   <= w_err;
        r_cnt   <= 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
      end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Array is not reset; the write commits on the acceptance edge.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && req_wen && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060077_riscv_dmem_resp.sv
// Scoreboard bench for the dmem responder: three instances at LATENCY 2, 1 and 15.
// Expected responses are queued at request time and compared when the response appears.
module tb_ysyx_23060077_riscv_dmem_resp;

  localparam int N = 3;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_wen    [N];
  logic [31:0] req_addr   [N];
  logic [1:0]  req_size   [N];
  logic [31:0] req_wdata  [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [31:0] resp_rdata [N];
  logic        resp_err   [N];

  resp_t sb[$];
  int    n_chk = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060077_riscv_dmem_resp #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  ysyx_23060077_riscv_dmem_resp #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  ysyx_23060077_riscv_dmem_resp #(.LATENCY(15)) u_dut_l15 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wen(req_wen[2]),
    .req_addr(req_addr[2]), .req_size(req_size[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  function automatic int lat_of(int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic chk_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle again.
  task automatic xact(int d, bit wen, logic [31:0] addr, logic [1:0] size,
                      logic [31:0] wd, logic [31:0] exp_rd, bit exp_err, int bp);
    resp_t e;
    int    n;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    chk_eq("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_size[d]  = size;
    req_wdata[d] = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = 32'h0;
    req_wdata[d] = 32'h0;
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_eq("latency", 32'(n), 32'(lat_of(d)));
    if (sb.size() == 0) begin
      chk_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk_eq("rdata", resp_rdata[d], e.rdata);
      chk_eq("err", 32'(resp_err[d]), 32'(e.err));
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk_eq("bp_valid", 32'(resp_valid[d]), 32'd1);
        chk_eq("bp_rdata", resp_rdata[d], e.rdata);
        chk_eq("bp_err", 32'(resp_err[d]), 32'(e.err));
        chk_eq("bp_req_ready", 32'(req_ready[d]), 32'd0);
      end
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk_eq("post_valid", 32'(resp_valid[d]), 32'd0);
    chk_eq("post_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      req_valid[d]  = 1'b0;
      req_wen[d]    = 1'b0;
      req_addr[d]   = 32'h0;
      req_size[d]   = 2'd0;
      req_wdata[d]  = 32'h0;
      resp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < N; d++) begin
      chk_eq("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk_eq("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk_eq("rst_rdata", resp_rdata[d], 32'd0);
      chk_eq("rst_err", 32'(resp_err[d]), 32'd0);
    end

    // Word store/load
    xact(0, 1, 32'h8000_0010, 2'd2, 32'hDEADBEEF, 32'h0, 0, 0);
    xact(0, 0, 32'h8000_0010, 2'd2, 32'h0, 32'hDEADBEEF, 0, 0);
    // Byte store into a known word; upper wdata bits must be ignored
    xact(0, 1, 32'h8000_0010, 2'd2, 32'h11223344, 32'h0, 0, 0);
    xact(0, 1, 32'h8000_0011, 2'd0, 32'hFFFF_FFAA, 32'h0, 0, 0);
    xact(0, 0, 32'h8000_0010, 2'd2, 32'h0, 32'h1122AA44, 0, 0);
    xact(0, 0, 32'h8000_0011, 2'd0, 32'h0, 32'h0000_00AA, 0, 0);
    // Half loads, zero-extended
    xact(0, 1, 32'h8000_0010, 2'd2, 32'h80017FFF, 32'h0, 0, 0);
    xact(0, 0, 32'h8000_0012, 2'd1, 32'h0, 32'h0000_8001, 0, 0);
    xact(0, 0, 32'h8000_0010, 2'd1, 32'h0, 32'h0000_7FFF, 0, 0);
    xact(0, 0, 32'h8000_0013, 2'd0, 32'h0, 32'h0000_0080, 0, 0);
    // Faults
    xact(0, 0, 32'h8000_0002, 2'd2, 32'h0, 32'h0, 1, 0);
    xact(0, 1, 32'h8000_0011, 2'd1, 32'h0000_BBBB, 32'h0, 1, 0);
    xact(0, 0, 32'h8000_0010, 2'd2, 32'h0, 32'h80017FFF, 0, 0);
    xact(0, 0, 32'h8000_0010, 2'd3, 32'h0, 32'h0, 1, 0);
    xact(0, 0, 32'h7FFF_FFFC, 2'd2, 32'h0, 32'h0, 1, 0);
    xact(0, 1, 32'h8000_1000, 2'd2, 32'h12345678, 32'h0, 1, 0);
    // Last word in range
    xact(0, 1, 32'h8000_0FFC, 2'd2, 32'hA5A5_5A5A, 32'h0, 0, 0);
    xact(0, 0, 32'h8000_0FFE, 2'd1, 32'h0, 32'h0000_A5A5, 0, 0);
    // Backpressure on a load
    xact(0, 0, 32'h8000_0010, 2'd2, 32'h0, 32'h80017FFF, 0, 5);

    // Reset while BUSY after a store is accepted
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b1;
    req_addr[0]  = 32'h8000_0020;
    req_size[0]  = 2'd2;
    req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk_eq("busy_req_ready", 32'(req_ready[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rst_busy_idle", 32'(req_ready[0]), 32'd1);
    chk_eq("rst_busy_valid", 32'(resp_valid[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("rst_busy_novalid", 32'(resp_valid[0]), 32'd0);
    end
    xact(0, 0, 32'h8000_0020, 2'd2, 32'h0, 32'hCAFEF00D, 0, 0);

    // Latency sweep
    xact(1, 1, 32'h8000_0040, 2'd2, 32'h0BAD_CAFE, 32'h0, 0, 0);
    xact(1, 0, 32'h8000_0042, 2'd1, 32'h0, 32'h0000_0BAD, 0, 2);
    xact(1, 0, 32'h8000_0041, 2'd2, 32'h0, 32'h0, 1, 0);
    xact(2, 1, 32'h8000_0044, 2'd2, 32'h1357_9BDF, 32'h0, 0, 0);
    xact(2, 0, 32'h8000_0044, 2'd0, 32'h0, 32'h0000_00DF, 0, 0);
    xact(2, 0, 32'h8000_0044, 2'd2, 32'h0, 32'h1357_9BDF, 0, 1);

    chk_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
